// File: rtl/hlp_ipp_pkg.sv
// Shared parser/classifier types and receiver defaults.
package hlp_ipp_pkg;

  // Parser result for one packet.
  typedef struct packed {
    logic [31:0] key;
    logic [15:0] pkt_len;
    logic [7:0]  flags;
  } parser_out_t;

  // Tail information for one packet; it arrives separately from the parser result.
  typedef struct packed {
    logic [15:0] byte_cnt;
    logic [3:0]  err;
    logic        eop;
  } tail_info_t;

  // Replication-management request, parser to classifier.
  typedef struct packed {
    logic        vld;
    logic        wr;
    logic [11:0] addr;
    logic [31:0] wdata;
  } imn_rpl_frwd_t;

  // Replication-management status, classifier to parser.
  typedef struct packed {
    logic        ack;
    logic [31:0] rdata;
  } imn_rpl_bkwd_t;

  // Header and tail of one packet after re-pairing.
  typedef struct packed {
    parser_out_t hdr;
    tail_info_t  tail;
  } cls_par_rec_t;

  localparam int CLS_PAR_HDR_DEPTH  = 8;
  localparam int CLS_PAR_TAIL_DEPTH = 8;

endpackage

// File: rtl/cls_par_rx_if.sv
// Parser input streams and the paired-record output stream of the receiver.
interface cls_par_rx_if;
  import hlp_ipp_pkg::*;

  parser_out_t parser_out;
  logic        parser_out_v;
  tail_info_t  o_tail_info;
  logic        o_tail_info_v;
  parser_out_t cls_hdr;
  tail_info_t  cls_tail;
  logic        cls_v;
  logic        cls_rdy;

  // Environment side: parser and classifier pipeline.
  modport master (
    output parser_out, parser_out_v, o_tail_info, o_tail_info_v, cls_rdy,
    input  cls_hdr, cls_tail, cls_v
  );

  // Receiver side.
  modport slave (
    input  parser_out, parser_out_v, o_tail_info, o_tail_info_v, cls_rdy,
    output cls_hdr, cls_tail, cls_v
  );
endinterface

// File: rtl/cls_par_fifo.sv
// Synchronous first-word-fall-through FIFO. A push into a full FIFO is
// accepted when a pop happens in the same cycle; otherwise it is dropped
// and reported by a one-cycle overflow pulse.
module cls_par_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   ovfl
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [AW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  // Accept/drop decisions; a simultaneous pop frees the slot for the push.
  always_comb begin
    do_pop  = 1'b0;
    do_push = 1'b0;
    ovfl    = 1'b0;
    if (pop && (cnt != '0)) begin
      do_pop = 1'b1;
    end else begin
      do_pop = 1'b0;
    end
    if (push && ((cnt != FULL_CNT) || do_pop)) begin
      do_push = 1'b1;
    end else begin
      do_push = 1'b0;
      ovfl    = push;
    end
  end

  // Storage array; cleared on reset so the head reads zero while empty after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= din;
    end
  end

  // Pointers (one extra wrap bit) and registered occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + (AW + 1)'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + (AW + 1)'(1);
      end
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (AW + 1)'(1);
        2'b01:   cnt <= cnt - (AW + 1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  assign head  = mem[rd_ptr[AW-1:0]];
  assign count = cnt;
  assign full  = (cnt == FULL_CNT);

endmodule

// File: rtl/cls_par_rx.sv
// Classifier-side receiver: buffers parser results and tail info in two
// FIFOs, re-pairs them in packet order and hands one record per packet to
// the classifier. Also retimes the replication-management paths.
module cls_par_rx
  import hlp_ipp_pkg::*;
#(
  parameter int HDR_DEPTH  = CLS_PAR_HDR_DEPTH,
  parameter int TAIL_DEPTH = CLS_PAR_TAIL_DEPTH
) (
  input  logic                        clk,
  input  logic                        rst,
  cls_par_rx_if.slave                 bus,
  input  imn_rpl_frwd_t               rpl_frwd_in,
  output imn_rpl_bkwd_t               rpl_bkwd_out,
  output imn_rpl_frwd_t               rpl_frwd_out,
  input  imn_rpl_bkwd_t               rpl_bkwd_in,
  output logic [$clog2(HDR_DEPTH):0]  hdr_cnt,
  output logic [$clog2(TAIL_DEPTH):0] tail_cnt,
  output logic [1:0]                  ovfl_err
);

  logic [$bits(parser_out_t)-1:0] hdr_head;
  logic [$bits(tail_info_t)-1:0]  tail_head;
  logic                           hdr_full;
  logic                           tail_full;
  logic                           hdr_ovfl;
  logic                           tail_ovfl;
  logic                           rec_v;
  logic                           pop_both;
  cls_par_rec_t                   head_rec;
  cls_par_rec_t                   hold_rec;
  cls_par_rec_t                   out_rec;
  logic                           unused_full;

  cls_par_fifo #(.WIDTH($bits(parser_out_t)), .DEPTH(HDR_DEPTH)) u_hdr_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.parser_out_v),
    .din   (bus.parser_out),
    .pop   (pop_both),
    .head  (hdr_head),
    .count (hdr_cnt),
    .full  (hdr_full),
    .ovfl  (hdr_ovfl)
  );

  cls_par_fifo #(.WIDTH($bits(tail_info_t)), .DEPTH(TAIL_DEPTH)) u_tail_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.o_tail_info_v),
    .din   (bus.o_tail_info),
    .pop   (pop_both),
    .head  (tail_head),
    .count (tail_cnt),
    .full  (tail_full),
    .ovfl  (tail_ovfl)
  );

  // Overflow is tracked through the drop pulses, so the full flags are not needed here.
  assign unused_full = hdr_full & tail_full;

  // A record exists once both heads are present; outputs hold the last record otherwise.
  always_comb begin
    head_rec.hdr  = parser_out_t'(hdr_head);
    head_rec.tail = tail_info_t'(tail_head);
    rec_v         = (hdr_cnt != '0) && (tail_cnt != '0);
    pop_both      = rec_v && bus.cls_rdy;
    if (rec_v) begin
      out_rec = head_rec;
    end else begin
      out_rec = hold_rec;
    end
  end

  // Remember the most recently presented record for the idle periods.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_rec <= '0;
    end else if (rec_v) begin
      hold_rec <= head_rec;
    end
  end

  // Sticky overflow flags: [0] header FIFO, [1] tail FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovfl_err <= 2'b00;
    end else begin
      ovfl_err <= ovfl_err | {tail_ovfl, hdr_ovfl};
    end
  end

  // One-cycle retiming of the management request and status paths.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rpl_frwd_out <= '0;
      rpl_bkwd_out <= '0;
    end else begin
      rpl_frwd_out <= rpl_frwd_in;
      rpl_bkwd_out <= rpl_bkwd_in;
    end
  end

  assign bus.cls_v    = rec_v;
  assign bus.cls_hdr  = out_rec.hdr;
  assign bus.cls_tail = out_rec.tail;

endmodule
